uart_rx_frame: RTL and testbench

Receive-side UART framer, directly downstream of the UART baud generator. It consumes a 1-cycle baud_tick enable running at OVERSAMPLE × bit rate and the raw rx line. It detects and validates the start bit, samples data bits at mid-bit, and checks optional parity and the stop bit. Each received byte goes to a consumer through a valid/ready register with error sideband flags.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx_frame.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, parity senses
// and default frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int unsigned PAR_EVEN       = 0;
    localparam int unsigned PAR_ODD        = 1;
    localparam int unsigned DEF_OVERSAMPLE = 16;
    localparam int unsigned DEF_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an idle-high serial line, plus a tick-aligned
// falling-edge detect against the value held at the previous baud tick.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_baud_tick,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            if (i_baud_tick) begin
                r_prev <= r_sync;
            end
        end
    end

    assign o_rx_s = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start-bit validation, mid-bit data sampling, optional
// parity and stop check, delivering bytes through a valid/ready register.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = PAR_EVEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          PAR_SENSE = (PARITY_ODD != 0);

    logic w_rx_s;
    logic w_fall;

    uart_rx_sync u_sync (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_baud_tick (baud_tick),
        .i_rx        (rx),
        .o_rx_s      (w_rx_s),
        .o_fall      (w_fall)
    );

    rx_state_e            r_state,   w_state_nx;
    logic [CW-1:0]        r_smp_cnt, w_smp_cnt_nx;
    logic [BW-1:0]        r_bit_cnt, w_bit_cnt_nx;
    logic [DATA_BITS-1:0] r_shift,   w_shift_nx;
    logic                 r_par_err, w_par_err_nx;
    logic                 w_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_smp_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_smp_cnt <= w_smp_cnt_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_shift   <= w_shift_nx;
            r_par_err <= w_par_err_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_smp_cnt_nx = r_smp_cnt;
        w_bit_cnt_nx = r_bit_cnt;
        w_shift_nx   = r_shift;
        w_par_err_nx = r_par_err;
        w_load       = 1'b0;
        if (baud_tick) begin
            unique case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        w_state_nx   = START;
                        w_smp_cnt_nx = '0;
                    end
                end
                START: begin
                    if (r_smp_cnt == CNT_HALF) begin
                        w_smp_cnt_nx = '0;
                        w_bit_cnt_nx = '0;
                        w_par_err_nx = 1'b0;
                        w_state_nx   = w_rx_s ? IDLE : DATA;
                    end else begin
                        w_smp_cnt_nx = r_smp_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (r_smp_cnt == CNT_FULL) begin
                        w_shift_nx   = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_smp_cnt_nx = '0;
                        w_bit_cnt_nx = r_bit_cnt + BW'(1);
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_nx = (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end else begin
                        w_smp_cnt_nx = r_smp_cnt + CW'(1);
                    end
                end
                PARITY: begin
                    if (r_smp_cnt == CNT_FULL) begin
                        w_par_err_nx = (^r_shift) ^ w_rx_s ^ PAR_SENSE;
                        w_smp_cnt_nx = '0;
                        w_state_nx   = STOP;
                    end else begin
                        w_smp_cnt_nx = r_smp_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (r_smp_cnt == CNT_FULL) begin
                        w_load       = 1'b1;
                        w_smp_cnt_nx = '0;
                        w_state_nx   = IDLE;
                    end else begin
                        w_smp_cnt_nx = r_smp_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nx   = IDLE;
                    w_smp_cnt_nx = '0;
                end
            endcase
        end
    end

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_perr;
    logic                 r_overrun;

    // A full register being drained in the same clk still takes the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_load) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_ferr  <= ~w_rx_s;
                    r_perr  <= (PARITY_EN != 0) && r_par_err;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: a no-parity instance and an even-parity
// instance, with baud_tick every 4 clk and 16x oversampling.
module tb_uart_rx_frame;

    localparam int unsigned BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick;
    logic       rx = 1'b1;
    logic       rx_p = 1'b1;
    logic       rx_ready = 1'b1;
    logic [1:0] tc = 2'd0;

    logic [7:0] rx_data,    rx_data_p;
    logic       rx_valid,   rx_valid_p;
    logic       frame_err,  frame_err_p;
    logic       parity_err, parity_err_p;
    logic       overrun,    overrun_p;
    logic       busy,       busy_p;

    always #5 clk = ~clk;
    always @(posedge clk) tc <= tc + 2'd1;
    assign baud_tick = (tc == 2'd3);

    uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
    );

    uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx_p),
        .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready),
        .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p), .busy(busy_p)
    );

    // Accepted words: {frame_err, parity_err, data}
    logic [9:0] q[$];
    logic [9:0] qp[$];
    int         n_ovr = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always @(negedge clk) begin
        if (rx_valid && rx_ready)     q.push_back({frame_err, parity_err, rx_data});
        if (rx_valid_p && rx_ready)   qp.push_back({frame_err_p, parity_err_p, rx_data_p});
        if (overrun || overrun_p)     n_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive_bit(input bit which, input logic b, input int unsigned nclk);
        if (which) rx_p = b; else rx = b;
        repeat (nclk) @(negedge clk);
    endtask

    task automatic send_frame(input bit which, input logic [7:0] d, input bit par_en,
                              input logic par, input logic stop);
        drive_bit(which, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i], BIT_CLK);
        if (par_en) drive_bit(which, par, BIT_CLK);
        drive_bit(which, stop, BIT_CLK);
    endtask

    initial begin
        logic [9:0] e;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({frame_err, parity_err, overrun}), 32'd0);

        // Clean frame
        q.delete();
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1, BIT_CLK);
        check("a5_count", 32'(q.size()), 32'd1);
        e = (q.size() > 0) ? q[0] : 10'h3FF;
        check("a5_word", 32'(e), 32'h0A5);
        check("a5_ovr", 32'(n_ovr), 32'd0);

        // Start glitch of 4 ticks
        q.delete();
        drive_bit(1'b0, 1'b0, 16);
        check("glitch_busy", 32'(busy), 32'd1);
        drive_bit(1'b0, 1'b1, 2 * BIT_CLK);
        check("glitch_idle", 32'(busy), 32'd0);
        check("glitch_none", 32'(q.size()), 32'd0);

        // Framing error then break
        q.delete();
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 3 * BIT_CLK);
        check("brk_busy", 32'(busy), 32'd0);
        drive_bit(1'b0, 1'b1, 2 * BIT_CLK);
        check("ferr_count", 32'(q.size()), 32'd1);
        e = (q.size() > 0) ? q[0] : 10'h3FF;
        check("ferr_word", 32'(e), 32'h23C);

        // Even parity: 0x07 has three ones, so a correct parity bit is 1
        qp.delete();
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        drive_bit(1'b1, 1'b1, BIT_CLK);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        drive_bit(1'b1, 1'b1, BIT_CLK);
        check("par_count", 32'(qp.size()), 32'd2);
        e = (qp.size() > 0) ? qp[0] : 10'h3FF;
        check("par_bad", 32'(e), 32'h107);
        e = (qp.size() > 1) ? qp[1] : 10'h3FF;
        check("par_good", 32'(e), 32'h007);

        // Overrun with consumer stalled
        q.delete();
        n_ovr = 0;
        rx_ready = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1, BIT_CLK);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1, BIT_CLK);
        check("ovr_pulses", 32'(n_ovr), 32'd1);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_data", 32'(rx_data), 32'h11);
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("ovr_drain", 32'(rx_valid), 32'd0);
        check("ovr_acc", 32'(q.size()), 32'd1);
        e = (q.size() > 0) ? q[0] : 10'h3FF;
        check("ovr_acc_word", 32'(e), 32'h011);

        // Reset in the middle of 0xFF, then 0x5A
        q.delete();
        n_ovr = 0;
        drive_bit(1'b0, 1'b0, BIT_CLK);
        drive_bit(1'b0, 1'b1, 3 * BIT_CLK);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        drive_bit(1'b0, 1'b1, 6 * BIT_CLK);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1, BIT_CLK);
        check("rst5a_count", 32'(q.size()), 32'd1);
        e = (q.size() > 0) ? q[0] : 10'h3FF;
        check("rst5a_word", 32'(e), 32'h05A);

        // Back-to-back frames
        q.delete();
        send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1, BIT_CLK);
        check("b2b_count", 32'(q.size()), 32'd2);
        e = (q.size() > 0) ? q[0] : 10'h3FF;
        check("b2b_first", 32'(e), 32'h000);
        e = (q.size() > 1) ? q[1] : 10'h3FF;
        check("b2b_second", 32'(e), 32'h0FF);
        check("end_ovr", 32'(n_ovr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
